// File: rtl/audio_dac_serializer.sv
// Buffered stereo DAC transmitter: small sample-pair FIFO feeding an I2S or
// left-justified serializer that generates its own bit clock and LR clock.
module audio_dac_serializer #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned BCLK_DIV   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        CLOCK_50,
  input  logic                        KEY0,
  input  logic                        enable,
  input  logic                        mode,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_left,
  input  logic [DATA_W-1:0]           s_right,
  output logic                        AUD_BCLK,
  output logic                        AUD_DACLRCK,
  output logic                        AUD_DACDAT,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;
  localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int unsigned IdxW = $clog2(2 * SLOT_W);

  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(2 * SLOT_W - 1);
  localparam logic [IdxW-1:0] SlotLen = IdxW'(SLOT_W);
  localparam logic [IdxW-1:0] DataLen = IdxW'(DATA_W);
  localparam logic [CntW-1:0] Depth   = CntW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              bclk_q, bclk_d;
  logic              lrck_q, lrck_d;
  logic              dat_q, dat_d;
  logic              und_q, und_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;

  logic [DATA_W-1:0] mem_l_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic fifo_empty, push, pop, frame_start;

  assign fifo_empty = (count_q == '0);
  assign s_ready    = (count_q != Depth);
  assign push       = s_valid && s_ready;
  // Emptiness is judged on the registered level: a same-cycle push never bypasses.
  assign pop        = frame_start && !fifo_empty;

  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dat_q;
  assign underrun    = und_q;
  assign fifo_level  = count_q;

  // Serial bit for frame index idx; I2S delays the MSB by one BCLK, left-justified does not.
  function automatic logic slot_bit(input logic [IdxW-1:0]   idx,
                                    input logic [DATA_W-1:0] l,
                                    input logic [DATA_W-1:0] r,
                                    input logic              md);
    logic [IdxW-1:0]   k;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] sh;
    logic              in_win;
    if (idx >= SlotLen) begin
      k = idx - SlotLen;
      s = r;
    end else begin
      k = idx;
      s = l;
    end
    if (md) begin
      in_win = (k < DataLen);
      sh     = s << k;
    end else begin
      in_win = (k != '0) && (k <= DataLen);
      sh     = s << (k - IdxW'(1));
    end
    return in_win & sh[DATA_W-1];
  endfunction

  // Clock generation, bit sequencing and frame-start loading.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    idx_d       = idx_q;
    bclk_d      = bclk_q;
    lrck_d      = lrck_q;
    dat_d       = dat_q;
    mode_d      = mode_q;
    left_d      = left_q;
    right_d     = right_q;
    und_d       = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      StIdle: begin
        div_d  = '0;
        idx_d  = '0;
        bclk_d = 1'b0;
        lrck_d = 1'b0;
        dat_d  = 1'b0;
        if (enable) begin
          state_d     = StRun;
          frame_start = 1'b1;
        end
      end
      StRun: begin
        if (div_q != DivLast) begin
          div_d = div_q + DivW'(1);
        end else begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          // LRCK and data only move on the BCLK falling edge.
          if (bclk_q) begin
            if (idx_q == IdxLast) begin
              if (enable) begin
                frame_start = 1'b1;
              end else begin
                state_d = StIdle;
                idx_d   = '0;
                lrck_d  = 1'b0;
                dat_d   = 1'b0;
              end
            end else begin
              idx_d  = idx_q + IdxW'(1);
              lrck_d = (idx_d >= SlotLen);
              dat_d  = slot_bit(idx_d, left_q, right_q, mode_q);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (frame_start) begin
      div_d   = '0;
      idx_d   = '0;
      bclk_d  = 1'b0;
      lrck_d  = 1'b0;
      mode_d  = mode;
      und_d   = fifo_empty;
      left_d  = fifo_empty ? '0 : mem_l_q[rd_ptr_q];
      right_d = fifo_empty ? '0 : mem_r_q[rd_ptr_q];
      dat_d   = mode & left_d[DATA_W-1];
    end
  end

  // FIFO pointer and level bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sample storage; contents are don't-care while the level says empty.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_l_q[wr_ptr_q] <= s_left;
      mem_r_q[wr_ptr_q] <= s_right;
    end
  end

  // State registers with asynchronous pushbutton reset.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q  <= StIdle;
      div_q    <= '0;
      idx_q    <= '0;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      dat_q    <= 1'b0;
      und_q    <= 1'b0;
      mode_q   <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      bclk_q   <= bclk_d;
      lrck_q   <= lrck_d;
      dat_q    <= dat_d;
      und_q    <= und_d;
      mode_q   <= mode_d;
      left_q   <= left_d;
      right_q  <= right_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer at default parameters: directed frame table,
// full/underrun/reset corner sequences, then randomized frames against a model.
module tb_audio_dac_serializer;

  logic        clk = 1'b0;
  logic        key0, enable, mode, s_valid, s_ready;
  logic [23:0] s_left, s_right;
  logic        bclk, lrck, dat, und;
  logic [2:0]  level;
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;

  localparam logic [63:0] LrExp = {32'h0000_0000, 32'hFFFF_FFFF};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_dac_serializer #(
    .DATA_W(24), .SLOT_W(32), .BCLK_DIV(2), .FIFO_DEPTH(4)
  ) dut (
    .CLOCK_50(clk), .KEY0(key0), .enable(enable), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat),
    .underrun(und), .fifo_level(level)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        md;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [5];

  // Reference: each slot is the sample left-aligned in 32 bits, shifted one later for I2S.
  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r,
                                            input logic md);
    logic [31:0] sl, sr;
    sl = {l, 8'h00};
    sr = {r, 8'h00};
    if (!md) begin
      sl = sl >> 1;
      sr = sr >> 1;
    end
    return {sl, sr};
  endfunction

  function automatic logic [7:0] outs();
    return {bclk, lrck, dat, und, s_ready, level};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic push_one(input logic [23:0] l, input logic [23:0] r);
    s_left = l; s_right = r; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_rising(input int cnt);
    int n; int guard; logic prev;
    n = 0; guard = 0; prev = bclk;
    while (n < cnt && guard < 1200) begin
      @(negedge clk);
      guard++;
      if (bclk && !prev) n++;
      prev = bclk;
    end
    if (n < cnt) begin
      n_total++;
      $display("FAIL wait_rising_timeout: got %0d edges want %0d", n, cnt);
    end
  endtask

  // Collects one frame of 64 BCLK rising-edge samples; after the first edge it
  // applies the next frame's mode, the enable level and an optional push.
  task automatic capture(input logic nmode, input logic do_push, input logic [23:0] pl,
                         input logic [23:0] pr, input logic keep_en, output logic [63:0] d,
                         output logic [63:0] lr, output int up, output int tf);
    int n; int guard; logic prev; logic pushing;
    n = 0; guard = 0; prev = bclk; pushing = 1'b0;
    d = '0; lr = '0; up = 0; tf = 0;
    while (n < 64 && guard < 1200) begin
      @(negedge clk);
      guard++;
      if (pushing) begin
        s_valid = 1'b0;
        pushing = 1'b0;
      end
      if (und) up++;
      if (bclk && !prev) begin
        d[63-n]  = dat;
        lr[63-n] = lrck;
        if (n == 0) tf = cyc;
        n++;
        if (n == 1) begin
          mode = nmode;
          enable = keep_en;
          if (do_push) begin
            s_left = pl; s_right = pr; s_valid = 1'b1; pushing = 1'b1;
          end
        end
      end
      prev = bclk;
    end
    if (pushing) s_valid = 1'b0;
    if (n < 64) begin
      n_total++;
      $display("FAIL capture_timeout: got %0d edges want 64", n);
    end
  endtask

  initial begin
    logic [63:0] d, lr;
    int          up, tf, tprev, k;
    logic        bad, cur_mode, nm, dp, was_empty;
    logic [23:0] pl, pr;
    logic [47:0] cur;
    logic [47:0] q [$];

    vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 1'b0, 64'h52D2D280_2D2D2D00};
    vecs[1] = '{24'h800001, 24'h123456, 1'b1, 64'h80000100_12345600};
    vecs[2] = '{24'hABCDEF, 24'hFEDCBA, 1'b1, 64'hABCDEF00_FEDCBA00};
    vecs[3] = '{24'hFFFFFF, 24'h000001, 1'b0, 64'h7FFFFF80_00000080};
    vecs[4] = '{24'h123456, 24'h654321, 1'b0, 64'h091A2B00_32A19080};

    // Reset with enable and s_valid high: everything quiet, nothing accepted.
    key0 = 1'b0; enable = 1'b1; mode = 1'b0; s_valid = 1'b1;
    s_left = 24'h111111; s_right = 24'h222222;
    @(negedge clk);
    check("reset_outs", 64'(outs()), 64'h08);
    repeat (5) @(negedge clk);
    check("reset_hold", 64'(outs()), 64'h08);
    s_valid = 1'b0; enable = 1'b0; key0 = 1'b1;
    @(negedge clk);

    // Fill: four accepted back to back, fifth held while full.
    for (int i = 0; i < 4; i++) begin
      s_left = vecs[i].l; s_right = vecs[i].r; s_valid = 1'b1;
      @(negedge clk);
    end
    s_left = vecs[4].l; s_right = vecs[4].r;
    repeat (3) @(negedge clk);
    check("full_level", 64'({s_ready, level}), 64'h4);
    mode = vecs[0].md;
    enable = 1'b1;
    @(negedge clk);
    check("first_pop", 64'({s_ready, level, und}), 64'({1'b1, 3'd3, 1'b0}));
    @(negedge clk);
    check("held_accept", 64'({s_ready, level}), 64'h4);
    s_valid = 1'b0;

    // Table frames, back to back, each with its own mode.
    tprev = 0;
    for (int i = 0; i < 5; i++) begin
      capture((i < 4) ? vecs[i+1].md : 1'b0, 1'b0, 24'h0, 24'h0, 1'b1, d, lr, up, tf);
      check($sformatf("frame%0d_data", i), d, vecs[i].exp);
      check($sformatf("frame%0d_lrck", i), lr, LrExp);
      check($sformatf("frame%0d_underrun", i), 64'(up), 64'd0);
      if (i > 0) check($sformatf("frame%0d_period", i), 64'(tf - tprev), 64'd256);
      tprev = tf;
    end

    // FIFO now empty: silent frame with one underrun pulse, then the pushed pair.
    capture(1'b1, 1'b1, vecs[1].l, vecs[1].r, 1'b1, d, lr, up, tf);
    check("underrun_data", d, 64'h0);
    check("underrun_lrck", lr, LrExp);
    check("underrun_pulses", 64'(up), 64'd1);
    capture(1'b0, 1'b0, 24'h0, 24'h0, 1'b0, d, lr, up, tf);
    check("recover_data", d, vecs[1].exp);
    check("recover_pulses", 64'(up), 64'd0);

    // enable dropped mid-frame: frame finished above, then quiet idle with no pop.
    repeat (3) @(negedge clk);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bad = bad | bclk | lrck | dat | und;
    end
    check("idle_quiet", 64'(bad), 64'h0);
    push_one(24'h0F0F0F, 24'hF0F0F0);
    @(negedge clk);
    check("idle_push", 64'({s_ready, level}), 64'({1'b1, 3'd1}));

    // Reset at left index 10, then restart with enable held high.
    mode = 1'b1;
    enable = 1'b1;
    wait_rising(11);
    #1 key0 = 1'b0;
    #1 check("midreset_async", 64'(outs()), 64'h08);
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_hold", 64'(outs()), 64'h08);
    s_valid = 1'b0; key0 = 1'b1;
    capture(1'b0, 1'b1, 24'h0F0F0F, 24'hF0F0F0, 1'b1, d, lr, up, tf);
    check("restart_data", d, 64'h0);
    check("restart_lrck", lr, LrExp);
    check("restart_pulses", 64'(up), 64'd1);
    capture(1'b0, 1'b0, 24'h0, 24'h0, 1'b0, d, lr, up, tf);
    check("restart_next", d, exp_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0));
    repeat (10) @(negedge clk);

    // Randomized frames against the queue model.
    key0 = 1'b0;
    repeat (2) @(negedge clk);
    key0 = 1'b1;
    @(negedge clk);
    k = $urandom_range(0, 4);
    for (int i = 0; i < k; i++) begin
      pl = 24'($urandom); pr = 24'($urandom);
      push_one(pl, pr);
      q.push_back({pl, pr});
    end
    cur_mode = 1'($urandom_range(0, 1));
    mode = cur_mode;
    @(negedge clk);
    enable = 1'b1;
    for (int f = 0; f < 8; f++) begin
      was_empty = (q.size() == 0);
      cur = was_empty ? 48'h0 : q.pop_front();
      nm = 1'($urandom_range(0, 1));
      dp = 1'($urandom_range(0, 1));
      pl = 24'($urandom); pr = 24'($urandom);
      capture(nm, dp, pl, pr, (f < 7), d, lr, up, tf);
      check($sformatf("rnd%0d_data", f), d, exp_frame(cur[47:24], cur[23:0], cur_mode));
      check($sformatf("rnd%0d_lrck", f), lr, LrExp);
      check($sformatf("rnd%0d_underrun", f), 64'(up), 64'(was_empty));
      if (dp) q.push_back({pl, pr});
      cur_mode = nm;
    end
    repeat (10) @(negedge clk);
    check("rnd_level", 64'(level), 64'(q.size()));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Parametrised I2S / left-justified DAC transmitter for the board audio codec path.
- Buffers stereo sample pairs from upstream logic in a small FIFO with a valid/ready handshake.
- Generates AUD_BCLK and AUD_DACLRCK from CLOCK_50 and shifts samples out on AUD_DACDAT.
- Generalises fixed-width, fixed-format codec output to configurable sample width, slot width, bit-clock rate and FIFO depth, plus runtime format select and underrun reporting.

Parameters:
- DATA_W, 24: sample width per channel. Legal range 8..32.
- SLOT_W, 32: BCLK periods per channel slot. Must be >= DATA_W+1.
- BCLK_DIV, 2: CLOCK_50 cycles per BCLK half-period. Must be >= 1.
- FIFO_DEPTH, 4: stereo pairs buffered. Must be a power of 2, >= 2.

Ports:
- CLOCK_50  in  1  system clock. Single clock domain.
- KEY0  in  1  reset: asynchronous assert, active-low (pushbutton reset).
- enable  in  1  1 = run serializer; 0 = idle.
- mode  in  1  0 = I2S (MSB one BCLK after LRCK edge); 1 = left-justified.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  FIFO not full.
- s_left  in  DATA_W  left sample.
- s_right  in  DATA_W  right sample.
- AUD_BCLK  out  1  bit clock.
- AUD_DACLRCK  out  1  0 = left slot, 1 = right slot.
- AUD_DACDAT  out  1  serial data.
- underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.
- fifo_level  out  clog2(FIFO_DEPTH)+1  pairs currently held.

Behaviour:
- Reset (KEY0=0, async): AUD_BCLK=0, AUD_DACLRCK=0, AUD_DACDAT=0, underrun=0, fifo_level=0, s_ready=1. FIFO is flushed and the FSM returns to IDLE.
- Reset mid-frame: outputs drop immediately; no partial frame resumes after release.
- All serial outputs are registered. s_ready = (fifo_level != FIFO_DEPTH).
- FIFO push: on s_valid && s_ready.
- FIFO push and pop in the same cycle: level unchanged.
- No bypass: a pop attempted while empty is an underrun, even if a push occurs in that same cycle.
- FSM IDLE:
  - BCLK, LRCK and DACDAT held 0; divider and bit counters cleared.
  - FIFO still accepts pushes.
  - enable=1 moves to RUN and performs frame-start on that same edge.
- FSM RUN:
  - Divider counts 0..BCLK_DIV-1; AUD_BCLK toggles at wrap.
  - Bit index 0..2*SLOT_W-1 advances on each BCLK falling edge.
  - Index 0..SLOT_W-1 is the left slot (LRCK=0); SLOT_W..2*SLOT_W-1 is the right slot (LRCK=1).
  - LRCK and DACDAT change only with BCLK falling; the codec samples them on BCLK rising.
- Frame-start (index wraps to 0, or IDLE->RUN):
  - FIFO non-empty: pop the pair into the left/right shift registers.
  - FIFO empty: load zeros, pulse underrun for 1 CLOCK_50 cycle, FIFO unchanged.
  - mode is sampled here only and held for the whole frame.
- Data placement, with slot offset k = bit index within slot:
  - mode 0: DACDAT = sample[DATA_W-1-(k-1)] for k = 1..DATA_W; 0 otherwise.
  - mode 1: DACDAT = sample[DATA_W-1-k] for k = 0..DATA_W-1; 0 otherwise.
- enable dropping to 0 in RUN: finish the current frame (through index 2*SLOT_W-1), then go to IDLE with all outputs 0. No pop at that boundary.
- Frame period: 4*SLOT_W*BCLK_DIV CLOCK_50 cycles (256 at defaults, i.e. 195.3 kHz).

Test Plan:
- Reset: KEY0=0 with enable=1 and s_valid=1 -> all serial outputs 0, s_ready=1, fifo_level=0, no push accepted.
- I2S: push L=0xA5A5A5, R=0x5A5A5A, then enable=1, mode=0 -> LRCK low for 32 BCLK.
  - Left slot bits sampled on BCLK rising: idx0=0, idx1..24 = 0xA5A5A5 MSB first, idx25..31 = 0.
  - Right slot carries 0x5A5A5A the same way.
  - LRCK period = 256 CLOCK_50 cycles.
- Left-justified: push L=0x800001, mode=1 -> idx0=1, idx1..22=0, idx23=1, idx24..31=0.
- Full: enable=0, push 5 pairs back-to-back -> 4 accepted, fifo_level=4, s_ready=0; 5th held until the first frame-start pop, then accepted next cycle.
- Underrun: enable=1 with FIFO empty -> underrun pulses exactly 1 cycle per frame, DACDAT=0 throughout; after a push, the next frame carries the data and shows no pulse.
- Reset mid-frame: KEY0 low at left idx10 -> outputs 0 asynchronously, fifo_level=0; after release with enable=1, a new frame starts at idx0 with LRCK=0.
